// File: rtl/key_expand.sv
// ---------------------------------------------------------------------------
// rcon / key_expand
//
// rcon: one key-schedule word transform. It rotates the input word left by one
// byte (RotWord), substitutes each byte through the AES S-box (SubWord), then
// XORs the round constant for round index 0..10 into the top byte.
//   rin   [31:0]  input word (w3 of the previous round key)
//   round [3:0]   round index 0..10 (11..15 use a zero constant)
//   rout  [31:0]  transformed word
//
// key_expand: iterative AES-128 key schedule. A start pulse captures the
// cipher key. The block then produces one round key per clock for 10 clocks
// and stores all 11 round keys in an internal register file. The round
// datapath reads the register file through a registered read port.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle request; captures key when the block is idle
//   key[127:0] cipher key, key[127:96] is w0 and key[31:0] is w3
//   busy       high while the expansion runs
//   done       one-cycle pulse after round key 10 is written
//   keys_valid high when all 11 round keys match the last accepted key
//   rk_addr    round key index to read, 0..10
//   rk_data    round key at rk_addr, one cycle after the address
// ---------------------------------------------------------------------------

module rcon (
    input  logic [31:0] rin,
    input  logic [3:0]  round,
    output logic [31:0] rout
);

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // The multiplicative inverse is a^254. The S-box maps 0 to 0, and this
    // power already gives that result, so zero needs no special case.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] e;
        r = 8'h01;
        p = a;
        e = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    // The S-box is computed from its definition (field inverse followed by the
    // affine transform) rather than stored as a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    logic [7:0]  rc;
    logic [31:0] rot;
    logic [31:0] sub;

    always_comb begin
        rc = 8'h00;
        case (round)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            4'd10:   rc = 8'h6c;
            default: rc = 8'h00;
        endcase
    end

    assign rot  = {rin[23:0], rin[31:24]};
    assign sub  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign rout = sub ^ {rc, 24'h000000};

endmodule

module key_expand (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data
);

    localparam int NUM_RK = 11;

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [3:0]   round;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  t, n0, n1, n2, n3;
    logic [127:0] rk [NUM_RK];
    logic [127:0] read_word;
    logic         accept;
    logic         last_step;

    // Only one key is ever in flight. A start that arrives while expanding is
    // dropped, and a start on the done cycle is legal because the state is
    // already back in IDLE.
    assign accept    = (state == IDLE) && start;
    assign last_step = (state == EXPAND) && (round == 4'd9);
    assign busy      = (state == EXPAND);

    rcon u_rcon (
        .rin   (w3),
        .round (round),
        .rout  (t)
    );

    // Next round's words. rcon and this XOR chain form one combinational path,
    // with no register between them.
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = EXPAND;
            EXPAND:  if (round == 4'd9) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The register file and the working words are updated here. A reset
    // clears every stored key, so an aborted expansion leaves no partial set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round      <= 4'd0;
            w0         <= 32'h0;
            w1         <= 32'h0;
            w2         <= 32'h0;
            w3         <= 32'h0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            for (int i = 0; i < NUM_RK; i++) rk[i] <= 128'h0;
        end else begin
            done <= last_step;
            if (accept) begin
                rk[0]      <= key;
                w0         <= key[127:96];
                w1         <= key[95:64];
                w2         <= key[63:32];
                w3         <= key[31:0];
                round      <= 4'd0;
                keys_valid <= 1'b0;
            end else if (state == EXPAND) begin
                for (int i = 1; i < NUM_RK; i++) begin
                    if (round == 4'(i - 1)) rk[i] <= {n0, n1, n2, n3};
                end
                w0    <= n0;
                w1    <= n1;
                w2    <= n2;
                w3    <= n3;
                round <= round + 4'd1;
                if (last_step) keys_valid <= 1'b1;
            end
        end
    end

    // Read mux. Addresses 11..15 match no entry and so read as zero.
    always_comb begin
        read_word = 128'h0;
        for (int i = 0; i < NUM_RK; i++) begin
            if (rk_addr == 4'(i)) read_word = rk[i];
        end
    end

    // Registered read. It samples the pre-edge register contents, so a read
    // and a write of the same index on one edge return the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rk_data <= 128'h0;
        else        rk_data <= read_word;
    end

endmodule

// File: tb/tb_key_expand.sv
// ---------------------------------------------------------------------------
// tb_key_expand: directed self-checking bench for key_expand.
// It applies the FIPS-197 key and the all-zero key, a start while busy,
// a back-to-back start on the done cycle, a reset during expansion, and
// read-port edge cases. The expected round keys are hand-entered constants.
// ---------------------------------------------------------------------------

module tb_key_expand;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;

    int nAsserts = 0;
    int nFail    = 0;

    localparam logic [127:0] FIPS_RK [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    key_expand dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data)
    );

    always #5 clk = ~clk;

    // One counted comparison.
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a key with start high for exactly one rising edge.
    task automatic applyStimulus(input logic [127:0] k);
        key   = k;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait for done, with a cycle budget of 30. The busy count includes the
    // cycle right after the start edge.
    task automatic waitDone(output int cycles, output int busyCycles);
        cycles     = 0;
        busyCycles = busy ? 1 : 0;
        while (cycles < 30 && !done) begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy) busyCycles++;
        end
    endtask

    task automatic readKey(input logic [3:0] a, output logic [127:0] d);
        rk_addr = a;
        @(posedge clk);
        #1;
        d = rk_data;
    endtask

    initial begin
        int           cyc;
        int           bcyc;
        int           pulses;
        logic [127:0] d;

        rst_n   = 1'b0;
        start   = 1'b0;
        key     = 128'h0;
        rk_addr = 4'd0;
        #12;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_keys_valid", keys_valid, 0);
        checkOutput("reset_rk_data", rk_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] FIPS-197 key");
        applyStimulus(FIPS_RK[0]);
        checkOutput("fips_busy_after_start", busy, 1);
        waitDone(cyc, bcyc);
        checkOutput("fips_latency", cyc, 10);
        checkOutput("fips_busy_cycles", bcyc, 10);
        checkOutput("fips_keys_valid", keys_valid, 1);
        for (int k = 0; k < 11; k++) begin
            rk_addr = 4'(k);
            if (k > 0) begin
                #2;
                checkOutput($sformatf("fips_hold%0d", k), rk_data, FIPS_RK[k-1]);
            end
            @(posedge clk);
            #1;
            checkOutput($sformatf("fips_rk%0d", k), rk_data, FIPS_RK[k]);
            if (k == 0) checkOutput("fips_done_one_cycle", done, 0);
        end
        readKey(4'd12, d);
        checkOutput("addr12_zero", d, 0);

        $display("[TB] zero key");
        applyStimulus(128'h0);
        waitDone(cyc, bcyc);
        checkOutput("zero_latency", cyc, 10);
        checkOutput("zero_busy_cycles", bcyc, 10);
        checkOutput("zero_keys_valid", keys_valid, 1);
        readKey(4'd1, d);
        checkOutput("zero_rk1", d, ZERO_RK1);
        readKey(4'd10, d);
        checkOutput("zero_rk10", d, ZERO_RK10);

        $display("[TB] start while busy");
        applyStimulus(FIPS_RK[0]);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        key   = 128'h0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_ignore_still_busy", busy, 1);
        waitDone(cyc, bcyc);
        checkOutput("busy_ignore_remaining", cyc, 6);
        pulses = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checkOutput("busy_ignore_no_second_done", pulses, 0);
        checkOutput("busy_ignore_keys_valid", keys_valid, 1);
        readKey(4'd10, d);
        checkOutput("busy_ignore_rk10", d, FIPS_RK[10]);
        readKey(4'd1, d);
        checkOutput("busy_ignore_rk1", d, FIPS_RK[1]);

        $display("[TB] back-to-back start on done");
        applyStimulus(FIPS_RK[0]);
        waitDone(cyc, bcyc);
        checkOutput("b2b_first_latency", cyc, 10);
        checkOutput("b2b_first_done", done, 1);
        applyStimulus(128'h0);
        checkOutput("b2b_keys_valid_drop", keys_valid, 0);
        checkOutput("b2b_busy", busy, 1);
        checkOutput("b2b_done_low", done, 0);
        waitDone(cyc, bcyc);
        checkOutput("b2b_second_latency", cyc, 10);
        checkOutput("b2b_keys_valid", keys_valid, 1);
        readKey(4'd1, d);
        checkOutput("b2b_rk1", d, ZERO_RK1);
        readKey(4'd10, d);
        checkOutput("b2b_rk10", d, ZERO_RK10);

        $display("[TB] reset mid-expansion");
        applyStimulus(FIPS_RK[0]);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_keys_valid", keys_valid, 0);
        checkOutput("midrst_rk_data", rk_data, 0);
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checkOutput("midrst_no_done", pulses, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 11; k++) begin
            readKey(4'(k), d);
            checkOutput($sformatf("midrst_rk%0d_cleared", k), d, 0);
        end
        checkOutput("midrst_idle", busy, 0);
        applyStimulus(FIPS_RK[0]);
        waitDone(cyc, bcyc);
        checkOutput("after_rst_latency", cyc, 10);
        readKey(4'd1, d);
        checkOutput("after_rst_rk1", d, FIPS_RK[1]);
        readKey(4'd10, d);
        checkOutput("after_rst_rk10", d, FIPS_RK[10]);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
